// File: rtl/core_pkg.sv
// core_pkg: shared br32 fetch types and constants
package core_pkg;
    typedef logic [31:0] pc_t;
    typedef struct packed {
        logic [31:0] instr;
        pc_t         pc;
    } fetch_entry_t;
    localparam int INSTR_BYTES = 4;
    localparam pc_t RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two FIFO with synchronous clear, combinational head and occupancy count
module fetch_fifo #(
    parameter type T = logic [31:0],
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count
);
    T mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign head = mem[rd_ptr];
    // pointers and occupancy; clear wins over push and pop
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // storage needs no reset: entries are only visible through count
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= push_data;
    end
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n || clr)
        !(push && !pop && count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n || clr)
        !(pop && count == '0));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: br32 instruction fetch front end; define FETCH_BYPASS_EN for a zero-latency empty-buffer bypass
module fetch_unit
    import core_pkg::*;
#(
    parameter pc_t RESET_PC = RESET_PC_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [1:0] {START, RUN, DRAIN} state_t;
    state_t state, state_nx;
    pc_t fetch_pc, resp_pc;
    logic [CW-1:0] drop_cnt, drop_nx, outstanding, fifo_count;
    fetch_entry_t head, out_entry, push_entry;
    logic req_fire, resp_keep, bypass, ibuf_push, ibuf_pop, ibuf_empty;

    assign ibuf_empty = fifo_count == '0;
    assign imem_req_valid = state != START && !redirect &&
                            ({1'b0, outstanding} + {1'b0, fifo_count} < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr = fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign resp_keep = imem_resp_valid && !redirect && drop_cnt == '0;
    assign push_entry = '{instr: imem_resp_data, pc: resp_pc};
`ifdef FETCH_BYPASS_EN
    assign bypass = resp_keep && ibuf_empty;
    assign out_entry = ibuf_empty ? push_entry : head;
`else
    assign bypass = 1'b0;
    assign out_entry = head;
`endif
    assign instr_valid = !redirect && (!ibuf_empty || bypass);
    assign instr = instr_valid ? out_entry.instr : '0;
    assign instr_pc = instr_valid ? out_entry.pc : '0;
    assign ibuf_pop = !ibuf_empty && instr_ready && !redirect;
    assign ibuf_push = resp_keep && !(bypass && instr_ready);

    fetch_fifo #(.T(pc_t), .DEPTH(FIFO_DEPTH)) pc_q (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .push(req_fire), .push_data(fetch_pc), .pop(imem_resp_valid),
        .head(resp_pc), .count(outstanding)
    );

    fetch_fifo #(.T(fetch_entry_t), .DEPTH(FIFO_DEPTH)) ibuf (
        .clk(clk), .rst_n(rst_n), .clr(redirect),
        .push(ibuf_push), .push_data(push_entry), .pop(ibuf_pop),
        .head(head), .count(fifo_count)
    );

    // redirect re-arms the drop count from everything still in flight after this edge
    always_comb begin
        drop_nx = redirect ? outstanding - CW'(imem_resp_valid) :
                  (imem_resp_valid && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
        state_nx = (state == START) ? RUN : (drop_nx != '0) ? DRAIN : RUN;
    end

    // fetch PC, drop count and FSM state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= START;
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            state <= state_nx;
            drop_cnt <= drop_nx;
            fetch_pc <= redirect ? (redirect_pc & ~pc_t'(INSTR_BYTES - 1)) :
                        req_fire ? fetch_pc + pc_t'(INSTR_BYTES) : fetch_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch_unit bench against a queue-based memory and delivery model
module tb_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] a;
    } ent_t;

    logic clk = 0, rst_n = 0, redirect = 0, imem_req_ready = 0, imem_resp_valid = 0, instr_ready = 0;
    logic [31:0] redirect_pc = 0, imem_resp_data = 0;
    logic imem_req_valid, instr_valid;
    logic [31:0] imem_req_addr, instr, instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    ent_t mem_q[$], buf_q[$], dlog[$];
    logic [31:0] rlog[$];
    logic [31:0] m_pc = RST_PC, salt = 0;
    int drop = 0, errors = 0, checks = 0;
    bit started = 0, in_rst = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t dl(input int i);
        return i < dlog.size() ? dlog[i] : 'x;
    endfunction

    function automatic logic [31:0] rl(input int i);
        return i < rlog.size() ? rlog[i] : 'x;
    endfunction

    // one clock: drive inputs, check outputs against the model, then advance the model
    task automatic step(input bit rst, input bit red, input logic [31:0] rpc,
                        input int rdy_pct, input int mrdy_pct, input int resp_pct);
        ent_t cur, exp_e;
        bit rv, ev_req, ev, byp, keep, fire;
        @(posedge clk);
        #1;
        rst_n = !rst;
        redirect = red;
        redirect_pc = rpc;
        instr_ready = $urandom_range(1, 100) <= rdy_pct;
        imem_req_ready = $urandom_range(1, 100) <= mrdy_pct;
        rv = !rst && mem_q.size() > 0 && $urandom_range(1, 100) <= resp_pct;
        imem_resp_valid = rv;
        imem_resp_data = rv ? mem_q[0].d : $urandom;
        @(negedge clk);
        if (rst) begin
            if (in_rst) begin
                chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
                chk("rst_instr_valid", {31'b0, instr_valid}, 0);
                chk("rst_req_addr", imem_req_addr, RST_PC);
                chk("rst_instr", instr, 0);
                chk("rst_instr_pc", instr_pc, 0);
            end
            mem_q.delete();
            buf_q.delete();
            m_pc = RST_PC;
            drop = 0;
            started = 0;
            in_rst = 1;
        end else begin
            in_rst = 0;
            ev_req = started && !red && (mem_q.size() + buf_q.size() < DEPTH);
            byp = 0;
`ifdef FETCH_BYPASS_EN
            byp = rv && !red && drop == 0 && buf_q.size() == 0;
`endif
            ev = !red && (buf_q.size() > 0 || byp);
            chk("req_valid", {31'b0, imem_req_valid}, {31'b0, ev_req});
            chk("req_addr", imem_req_addr, m_pc);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, ev});
            if (ev) begin
                exp_e = buf_q.size() > 0 ? buf_q[0] : mem_q[0];
                chk("instr", instr, exp_e.d);
                chk("instr_pc", instr_pc, exp_e.a);
            end
            if (imem_req_valid && imem_req_ready) rlog.push_back(imem_req_addr);
            if (instr_valid && instr_ready) dlog.push_back('{d: instr, a: instr_pc});
            fire = ev_req && imem_req_ready;
            keep = 0;
            if (rv) begin
                cur = mem_q.pop_front();
                keep = !red && drop == 0;
                if (!red && drop > 0) drop--;
            end
            if (ev && instr_ready && buf_q.size() > 0) void'(buf_q.pop_front());
            if (keep && !(byp && instr_ready)) buf_q.push_back(cur);
            if (fire) begin
                mem_q.push_back('{d: m_pc ^ KEY ^ salt, a: m_pc});
                m_pc += 4;
            end
            if (red) begin
                buf_q.delete();
                m_pc = {rpc[31:2], 2'b00};
                drop = mem_q.size();
            end
            started = 1;
        end
    endtask

    initial begin
        int mr, md;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 100, 100);
        chk("start_no_req", {31'b0, imem_req_valid}, 0);
        repeat (9) step(0, 0, 0, 0, 100, 100);
        chk("stall_valid", {31'b0, instr_valid}, 1);
        chk("stall_instr", instr, 32'hA5A5_0000);
        chk("stall_pc", instr_pc, 32'h0);
        chk("stall_no_req", {31'b0, imem_req_valid}, 0);
        repeat (6) step(0, 0, 0, 100, 100, 100);
        chk("req0", rl(0), 32'h0);
        chk("req1", rl(1), 32'h4);
        chk("req2", rl(2), 32'h8);
        chk("d0_pc", dl(0).a, 32'h0);
        chk("d0_instr", dl(0).d, 32'hA5A5_0000);
        chk("d1_pc", dl(1).a, 32'h4);
        chk("d1_instr", dl(1).d, 32'hA5A5_0004);
        repeat (4) step(0, 0, 0, 100, 100, 0);
        chk("credit_full", {31'b0, imem_req_valid}, 0);
        mr = rlog.size();
        md = dlog.size();
        step(0, 1, 32'h1003, 100, 100, 0);
        repeat (10) step(0, 0, 0, 100, 100, 100);
        chk("redir_req", rl(mr), 32'h1000);
        chk("redir_pc", dl(md).a, 32'h1000);
        chk("redir_instr", dl(md).d, 32'hA5A5_1000);
        repeat (4) step(0, 0, 0, 100, 100, 0);
        step(0, 1, 32'h1800, 100, 100, 0);
        step(0, 0, 0, 100, 100, 100);
        md = dlog.size();
        step(0, 1, 32'h2000, 100, 100, 100);
        repeat (10) step(0, 0, 0, 100, 100, 100);
        chk("drain_redir_pc", dl(md).a, 32'h2000);
        mr = rlog.size();
        step(0, 1, 32'hFFFF_FFF8, 100, 100, 100);
        repeat (10) step(0, 0, 0, 100, 100, 100);
        chk("wrap_req0", rl(mr), 32'hFFFF_FFF8);
        chk("wrap_req1", rl(mr + 1), 32'hFFFF_FFFC);
        chk("wrap_req2", rl(mr + 2), 32'h0000_0000);
        salt = $urandom;
        md = dlog.size();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500 || i == 1501) step(1, 0, 0, 0, 0, 0);
            else step(0, $urandom_range(1, 100) <= 4, $urandom, 70, 70, 60);
        end
        chk("progress", {31'b0, dlog.size() - md > 500}, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end for the br32 core. It produces the 32-bit instruction words the decoder consumes.
- Issues word-aligned PC requests to instruction memory and buffers in-order responses in a small FIFO.
- Presents {instr, pc} to decode with a valid/ready handshake.
- Handles redirects (branch/exception/eret targets) by discarding stale in-flight responses and buffered words.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  core clock
rst_n  input  1  synchronous active-low reset
redirect  input  1  load new fetch PC this cycle; flush everything
redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced 0)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_resp_valid  input  1  response data valid; in order; never back-pressured
imem_resp_data  input  32  instruction word
instr_valid  output  1  instruction available to decode
instr_ready  input  1  decode accepts instruction
instr  output  32  instruction word to decoder
instr_pc  output  32  address of instr

Behaviour:
- Reset: this is the one clock, synchronous, active-low reset (rst_n sampled on clk rising edge).
  - State: fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty, state=START.
  - Outputs: imem_req_valid=0, instr_valid=0, imem_req_addr=RESET_PC, instr=0, instr_pc=0.
  - Reset mid-operation abandons all in-flight requests. Memory is reset in the same cycle.
- FSM states:
  - START: one cycle, no request. Always goes to RUN.
  - RUN: drop_cnt==0.
  - DRAIN: drop_cnt>0.
  - RUN->DRAIN on redirect with (outstanding + issued-this-cycle − returned-this-cycle) > 0.
  - DRAIN->RUN when the last dropped response arrives and no new redirect occurs.
- Request issue:
  - imem_req_valid = (state!=START) && !redirect && (outstanding + fifo_count < FIFO_DEPTH).
  - This credit rule guarantees every response has a FIFO slot.
  - imem_req_addr = fetch_pc. On handshake, fetch_pc += 4, wrapping 0xFFFF_FFFC -> 0.
- Request tracking:
  - Outstanding counter is ceil(log2(FIFO_DEPTH+1)) bits. It increments on handshake and decrements on response.
  - A PC FIFO (or a pc-of-next-response register) tracks the address of each in-flight request.
- Response:
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise push {data, pc} into the FIFO.
- Decode side:
  - instr_valid = FIFO non-empty. instr/instr_pc = FIFO head.
  - Pop on instr_valid && instr_ready.
  - Base latency: response at cycle N -> instr_valid at N+1.
  - Output must stay stable while instr_valid && !instr_ready.
- Redirect (highest priority):
  - Same cycle: imem_req_valid=0 and instr_valid=0.
  - Next edge:
    - FIFO cleared.
    - fetch_pc = {redirect_pc[31:2], 2'b00}.
    - drop_cnt = all requests in flight after this edge.
    - A response arriving in the redirect cycle is discarded and not counted.
  - First new request is issued the cycle after redirect.
- Redirect during DRAIN: drop_cnt is recomputed from the current in-flight count. No double counting.
- Simultaneous push and pop on a full FIFO is legal. The credit rule makes overflow impossible; an assertion checks this.
- Empty FIFO with instr_ready=1: no pop, instr_valid=0.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, drop_cnt==0 and a response arrives without redirect:
  - instr_valid=1 combinationally in the same cycle, with instr=imem_resp_data and instr_pc = pc of the response.
  - If instr_ready=1, the word is consumed and not pushed. Otherwise it is pushed.
  - Latency 0 cycles.
- Undefined: always 1-cycle registered latency through the FIFO, and no combinational path from imem_resp_* to instr_*.

Decomposition:
- Shared package core_pkg:
  - pc_t (logic [31:0]).
  - fetch_entry_t struct {instr, pc}.
  - INSTR_BYTES=4.
  - RESET_PC default constant.
- Sub-module fetch_fifo:
  - Parameterised on entry type and depth.
  - Synchronous clear, push/pop, count output.
  - Used for both the instruction buffer and the in-flight PC queue.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr^32'hA5A5_0000:
  - No request in the cycle after reset.
  - Then requests at 0x0, 0x4, 0x8.
  - instr/instr_pc = (0xA5A5_0000, 0x0), (0xA5A5_0004, 0x4) delivered in order.
- instr_ready=0 for 10 cycles:
  - FIFO fills to 2 and imem_req_valid drops.
  - instr holds 0x0's word stable.
  - Release -> no loss or duplication.
- Redirect to 0x1003 with 2 requests outstanding:
  - Both late responses are discarded.
  - Next request addr=0x1000.
  - First delivered instr_pc=0x1000.
- Second redirect to 0x2000 during DRAIN, one response arriving the same cycle:
  - That response is dropped.
  - Only instructions from 0x2000 onward appear.
- Redirect to 0xFFFF_FFF8: fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- FETCH_BYPASS_EN on, FIFO empty, instr_ready=1, response at cycle N:
  - instr_valid in cycle N, FIFO count stays 0.
  - Feature off: instr_valid at N+1.
